// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: PC/IF-ID/DE write enables, flush/bubble, divider sequencing.
// Optional build macro HAZARD_FORWARD_EN: when defined, only load-use against E stalls (E/M forwarding present).
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Drs,
  input  logic [4:0] Drt,
  input  logic       Duse_rs,
  input  logic       Duse_rt,
  input  logic [4:0] Ern,
  input  logic       Ew_rf,
  input  logic       Eload,
  input  logic       Ediv,
  input  logic       EisGoto,
  input  logic [4:0] Mrn,
  input  logic       Mw_rf,
  output logic       pc_wena,
  output logic       fd_wena,
  output logic       fd_flush,
  output logic       de_wena,
  output logic       de_bubble,
  output logic       div_start,
  output logic       div_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic e_rs, e_rt, m_rs, m_rt, data_stall;

  // Register $0 is hardwired zero, so it never forms a dependency.
  assign e_rs = Duse_rs && (Drs != 5'd0) && Ew_rf && (Drs == Ern);
  assign e_rt = Duse_rt && (Drt != 5'd0) && Ew_rf && (Drt == Ern);
  assign m_rs = Duse_rs && (Drs != 5'd0) && Mw_rf && (Drs == Mrn);
  assign m_rt = Duse_rt && (Drt != 5'd0) && Mw_rf && (Drt == Mrn);

`ifdef HAZARD_FORWARD_EN
  logic unused_m_match;
  assign unused_m_match = m_rs ^ m_rt;
  assign data_stall     = Eload && (e_rs || e_rt);
`else
  logic unused_eload;
  assign unused_eload = Eload;
  // Without forwarding, the stall repeats until the producer has retired past M.
  assign data_stall   = e_rs || e_rt || m_rs || m_rt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_wena   = 1'b1;
    fd_wena   = 1'b1;
    de_wena   = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    div_start = 1'b0;
    div_busy  = 1'b0;
    case (state)
      IDLE: begin
        // Gate with rst so no start pulse escapes while the divider is held in reset.
        if (Ediv && !rst) begin
          div_start = 1'b1;
          pc_wena   = 1'b0;
          fd_wena   = 1'b0;
          de_wena   = 1'b0;
          state_nxt = DIV_BUSY;
          cnt_nxt   = CNT_LOAD;
        end else if (EisGoto) begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end else if (data_stall) begin
          pc_wena   = 1'b0;
          fd_wena   = 1'b0;
          de_bubble = 1'b1;
        end
      end
      DIV_BUSY: begin
        div_busy = 1'b1;
        pc_wena  = 1'b0;
        fd_wena  = 1'b0;
        de_wena  = 1'b0;
        if (cnt == 8'd0) state_nxt = DIV_DONE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      DIV_DONE: begin
        // Ediv is still high here; returning to IDLE lets the div leave E without a restart.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
